// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the mips16 single-port data memory.
// Port 0 is the CPU load/store path, port 1 the DMA/program loader. One access is
// in flight at a time: IDLE picks and latches a command, ACCESS drives the memory,
// RDATA returns read data with a one-cycle rvalid pulse on the owning port.
module dmem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic              port;
    } cmd_t;

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              last_gnt_q;
    logic              any_req;
    logic              win;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    // Arbitration: a lone requester wins; a tie goes to port 0 under fixed
    // priority, otherwise to the port that did not win last time.
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1)
            win = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt_q;
        else
            win = req1;
        cmd_d.port  = win;
        cmd_d.we    = win ? we1    : we0;
        cmd_d.addr  = win ? addr1  : addr0;
        cmd_d.wdata = win ? wdata1 : wdata0;
    end

    // Next state and memory-side outputs; the bus is quiet outside ACCESS.
    always_comb begin
        state_d   = state_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = ACCESS;
            end
            ACCESS: begin
                busy      = 1'b1;
                mem_addr  = cmd_q.addr;
                mem_wdata = cmd_q.wdata;
                mem_we    = cmd_q.we;
                mem_re    = ~cmd_q.we;
                gnt0      = ~cmd_q.port;
                gnt1      = cmd_q.port;
                state_d   = cmd_q.we ? IDLE : RDATA;
            end
            RDATA: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, command capture in IDLE, and read-data return from RDATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            last_gnt_q <= 1'b1;
            rvalid_q   <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= 2'b00;
            if (state_q == IDLE && any_req) begin
                cmd_q      <= cmd_d;
                last_gnt_q <= win;
            end
            if (state_q == RDATA) begin
                rvalid_q[cmd_q.port] <= 1'b1;
                if (cmd_q.port) rdata1_q <= mem_rdata;
                else            rdata0_q <= mem_rdata;
            end
        end
    end

    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port 16-bit data memory of the mips16 core. Port 0 is the CPU load/store path and port 1 is the DMA/program-loader path. Each cycle it selects at most one requester, presents that access to the memory and returns read data with a valid pulse. Selection is round-robin by default, with an optional fixed priority for port 0.

## Interface
Parameters:
- `ADDR_W`, 16, address width of both ports and the memory.
- `DATA_W`, 16, data width.
- `FIXED_PRIO`, 0. When 0, ties are resolved round-robin. When 1, port 0 always wins a tie.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  access request from port 0 / port 1.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  byte address; passed through unmodified.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `gnt0` / `gnt1`  out  1  one-cycle pulse; the port's access is on the memory bus this cycle.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse; `rdataN` is valid.
- `rdata0` / `rdata1`  out  DATA_W  registered read data; holds its value until the next read completes on that port.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_re`  out  1  memory read enable.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_re`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ACCESS, RDATA.
- IDLE, no request: stay in IDLE.
- IDLE, any `reqN` high:
  - Pick a winner. With a single requester, it wins.
  - With both requesting and `FIXED_PRIO=0`, the winner is the port not recorded in `last_gnt`. With `FIXED_PRIO=1`, port 0 wins.
  - Latch the winner's `addr`, `wdata`, `we` and port id into the command registers.
  - Update `last_gnt` to the winner. Go to ACCESS.
- ACCESS:
  - Drive `mem_addr` and `mem_wdata` from the command registers.
  - Assert `mem_we` = `we_q` or `mem_re` = `!we_q`, and `gnt` of the latched port.
  - A write goes to IDLE; a read goes to RDATA.
- RDATA:
  - `mem_rdata` is valid. Register it into `rdata` of the latched port and set that port's `rvalid` for the next cycle. Go to IDLE.
- The `rvalid` pulse coincides with the following IDLE cycle. A new arbitration in that same cycle is allowed.
- Handshake rules:
  - A requester holds `req`, `we`, `addr` and `wdata` stable from assertion until it observes `gnt`.
  - Command fields are captured in IDLE, so later input changes do not affect an accepted access.
  - `req` still high in the cycle after `gnt` is a new request.
- Only the latched port's `gnt` and `rvalid` ever assert; `gnt0 & gnt1` and `rvalid0 & rvalid1` are never both 1.
- Outside ACCESS, `mem_we`, `mem_re`, `mem_addr` and `mem_wdata` are 0.
- Fairness: with `FIXED_PRIO=0` and both ports requesting continuously, grants alternate 0,1,0,1…
- Starvation of port 1 with `FIXED_PRIO=1` is the intended behaviour.

## Timing
- Reset (synchronous; takes effect at the edge where `reset`=1, mid-transaction included):
  - State goes to IDLE; any in-flight access is abandoned and no `gnt` or `rvalid` follows.
  - All outputs are 0: `gnt*`, `rvalid*`, `rdata*`, `mem_*`, `busy`.
  - `last_gnt` = 1, so port 0 wins the first tie.
- Cycle numbering, with the request sampled in IDLE at cycle 0:
  - `gnt` and the memory command assert in cycle 1.
  - Write: IDLE again in cycle 2.
  - Read: RDATA in cycle 2; `rvalid` and `rdata` in cycle 3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- `busy` = 1 in ACCESS and RDATA.
- `req` sampled only in IDLE. A request that is raised and dropped while the FSM is busy is never seen; this is allowed but not a supported protocol use.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles. Assert `reset` during RDATA of a read: no `rvalid` afterwards, `rdata0` = 0.
- Port 0 write `addr0`=0x0010, `wdata0`=0xBEEF: `gnt0`, `mem_we`=1, `mem_addr`=0x0010 and `mem_wdata`=0xBEEF in cycle 1; `busy` low in cycle 2. Port 0 read of 0x0010: `mem_re` in cycle 1, `rvalid0`=1 with `rdata0`=0xBEEF in cycle 3.
- Simultaneous first requests (port 0 read 0x0020, port 1 write 0x0030=0x1234) after reset: `gnt0` first (cycle 1), then `gnt1` in cycle 4; `rvalid1` never asserts.
- Both ports requesting continuously for 12 grants with `FIXED_PRIO=0`: grant sequence strictly alternates, 6 each. Same stimulus with `FIXED_PRIO=1`: 12 grants to port 0, none to port 1.
- Port 1 changes `addr1` from 0x0040 to 0x0050 in the ACCESS cycle of its granted read: `mem_addr` = 0x0040 throughout; `rdata1` returns the contents of 0x0040.
- Back-to-back reads on port 0 with `req0` held: `gnt0` in cycles 1 and 4. `rvalid0` in cycle 3 overlaps the IDLE cycle that accepts the second read. `rdata0` holds the first value until cycle 6.
